// File: rtl/tetris_input_ctrl.sv
// Keycode to frame-synchronous game-action pulses.
// DAS shifting, repeating soft drop, edge rotation, pause toggle.
module tetris_input_ctrl #(
  parameter int DAS_DELAY   = 16,
  parameter int DAS_REPEAT  = 6,
  parameter int DROP_PERIOD = 2
) (
  input  logic       Clk,
  input  logic       Reset_h,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic       move_left,
  output logic       move_right,
  output logic       rotate_cw,
  output logic       rotate_ccw,
  output logic       soft_drop,
  output logic       paused
);

  localparam int CW = $clog2(DAS_DELAY + 1);
  localparam int DW = $clog2(DROP_PERIOD + 1);

  localparam logic [7:0] K_LEFT  = 8'h50;
  localparam logic [7:0] K_RIGHT = 8'h4F;
  localparam logic [7:0] K_DOWN  = 8'h51;
  localparam logic [7:0] K_X     = 8'h1B;
  localparam logic [7:0] K_Z     = 8'h1D;
  localparam logic [7:0] K_P     = 8'h13;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } das_e;

  das_e          state, state_n;
  logic          dir, dir_n;
  logic [CW-1:0] das_cnt, das_n, das_inc, das_lim;
  logic [DW-1:0] drop_cnt, drop_n, drop_inc;
  logic [7:0]    prev_key, prev_n;
  logic          paused_n;
  logic          l_n, r_n, cw_n, ccw_n, sd_n;
  logic          press, is_l, is_r, is_d;
  logic          held, fresh;

  assign press    = keycode != prev_key;
  assign is_l     = keycode == K_LEFT;
  assign is_r     = keycode == K_RIGHT;
  assign is_d     = keycode == K_DOWN;
  assign das_inc  = das_cnt + CW'(1);
  assign drop_inc = drop_cnt + DW'(1);
  assign das_lim  = (state == DELAY) ? CW'(DAS_DELAY) : CW'(DAS_REPEAT);
  assign held     = dir ? is_r : is_l;

  // Per-tick decisions: pause, DAS, soft drop, rotation.
  always_comb begin
    state_n  = state;
    dir_n    = dir;
    das_n    = das_cnt;
    drop_n   = drop_cnt;
    prev_n   = prev_key;
    paused_n = paused;
    l_n      = 1'b0;
    r_n      = 1'b0;
    cw_n     = 1'b0;
    ccw_n    = 1'b0;
    sd_n     = 1'b0;
    fresh    = 1'b0;
    if (frame_tick) begin
      prev_n = keycode;
      if (press && keycode == K_P)
        paused_n = ~paused;
      if (paused_n) begin
        state_n = IDLE;
        das_n   = '0;
        drop_n  = '0;
      end else begin
        cw_n  = press && keycode == K_X;
        ccw_n = press && keycode == K_Z;
        if (is_d) begin
          if (press) begin
            sd_n   = 1'b1;
            drop_n = '0;
          end else if (drop_inc == DW'(DROP_PERIOD)) begin
            sd_n   = 1'b1;
            drop_n = '0;
          end else begin
            drop_n = drop_inc;
          end
        end else begin
          drop_n = '0;
        end
        unique case (state)
          IDLE: fresh = press && (is_l || is_r);
          DELAY, REPEAT: begin
            if (held) begin
              if (das_inc == das_lim) begin
                l_n     = ~dir;
                r_n     = dir;
                das_n   = '0;
                state_n = REPEAT;
              end else begin
                das_n = das_inc;
              end
            end else if (is_l || is_r) begin
              fresh = 1'b1;
            end else begin
              state_n = IDLE;
              das_n   = '0;
            end
          end
          default: state_n = IDLE;
        endcase
        if (fresh) begin
          l_n     = is_l;
          r_n     = is_r;
          dir_n   = is_r;
          das_n   = '0;
          state_n = DELAY;
        end
      end
    end
  end

  // State and registered one-cycle pulses.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      state      <= IDLE;
      dir        <= 1'b0;
      das_cnt    <= '0;
      drop_cnt   <= '0;
      prev_key   <= 8'h00;
      paused     <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      rotate_cw  <= 1'b0;
      rotate_ccw <= 1'b0;
      soft_drop  <= 1'b0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      das_cnt    <= das_n;
      drop_cnt   <= drop_n;
      prev_key   <= prev_n;
      paused     <= paused_n;
      move_left  <= l_n;
      move_right <= r_n;
      rotate_cw  <= cw_n;
      rotate_ccw <= ccw_n;
      soft_drop  <= sd_n;
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl.
// Pulse vector order: left, right, cw, ccw, drop.
module tb_tetris_input_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_h = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       move_left, move_right, rotate_cw, rotate_ccw, soft_drop;
  logic       paused;
  logic [4:0] pulses;
  logic [4:0] p;

  localparam logic [4:0] NO  = 5'b00000;
  localparam logic [4:0] L   = 5'b10000;
  localparam logic [4:0] R   = 5'b01000;
  localparam logic [4:0] XCW = 5'b00100;
  localparam logic [4:0] ZCC = 5'b00010;
  localparam logic [4:0] SD  = 5'b00001;

  int n_chk = 0;
  int n_fail = 0;

  tetris_input_ctrl dut (
    .Clk        (Clk),
    .Reset_h    (Reset_h),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .move_left  (move_left),
    .move_right (move_right),
    .rotate_cw  (rotate_cw),
    .rotate_ccw (rotate_ccw),
    .soft_drop  (soft_drop),
    .paused     (paused)
  );

  assign pulses = {move_left, move_right, rotate_cw, rotate_ccw, soft_drop};

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    frame_tick = 1'b0;
    keycode    = 8'h00;
    Reset_h    = 1'b1;
    #1;
    check("rst_pulses", pulses, NO);
    check("rst_paused", paused, 0);
    @(negedge Clk);
    Reset_h = 1'b0;
  endtask

  // One tick, then one idle cycle where every pulse must be low.
  task automatic tick(input logic [7:0] k, output logic [4:0] o);
    @(negedge Clk);
    keycode    = k;
    frame_tick = 1'b1;
    @(posedge Clk);
    #1 o = pulses;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(posedge Clk);
    #1 check("width", pulses, NO);
  endtask

  initial begin
    apply_reset();

    // Left held 40 ticks: pulses at 0,16,22,28,34.
    for (int i = 0; i < 40; i++) begin
      tick(8'h50, p);
      check($sformatf("das_l%0d", i), p,
            (i == 0 || i == 16 || i == 22 || i == 28 || i == 34) ? L : NO);
    end

    // Left 0..9 then right: left at 0, right at 10 and 26.
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      tick(i < 10 ? 8'h50 : 8'h4F, p);
      check($sformatf("rev%0d", i), p,
            i == 0 ? L : (i == 10 || i == 26) ? R : NO);
    end

    // Reset during REPEAT, asserted while a pulse is high.
    apply_reset();
    for (int i = 0; i < 22; i++) tick(8'h50, p);
    @(negedge Clk);
    keycode    = 8'h50;
    frame_tick = 1'b1;
    @(posedge Clk);
    #1 check("pre_rst", pulses, L);
    Reset_h = 1'b1;
    #1 check("async_rst", pulses, NO);
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
    Reset_h = 1'b0;
    tick(8'h50, p);
    check("post_rst_fresh", p, L);
    tick(8'h50, p);
    check("post_rst_hold", p, NO);

    // Rotation: edge only.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick(8'h1B, p);
      check($sformatf("cw%0d", i), p, i == 0 ? XCW : NO);
    end
    tick(8'h1D, p);
    check("ccw0", p, ZCC);
    tick(8'h00, p);
    check("ccw1", p, NO);
    tick(8'h1D, p);
    check("ccw2", p, ZCC);

    // Soft drop: 0, 2, 4; release clears.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick(8'h51, p);
      check($sformatf("drop%0d", i), p, (i % 2 == 0) ? SD : NO);
    end
    tick(8'h00, p);
    check("drop_rel", p, NO);
    tick(8'h51, p);
    check("drop_again", p, SD);

    // Pause toggle.
    apply_reset();
    tick(8'h13, p);
    check("pause_p", p, NO);
    check("paused_on", paused, 1);
    for (int i = 0; i < 20; i++) begin
      tick(8'h50, p);
      check($sformatf("paused_l%0d", i), p, NO);
    end
    tick(8'h13, p);
    check("paused_off", paused, 0);
    check("unpause_p", p, NO);
    tick(8'h50, p);
    check("unpause_l", p, L);

    // Keycode change between ticks is invisible.
    apply_reset();
    tick(8'h00, p);
    @(negedge Clk);
    keycode = 8'h1B;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1 check("no_tick", pulses, NO);
    end
    tick(8'h00, p);
    check("hidden_key", p, NO);

    // Back-to-back ticks.
    @(negedge Clk);
    keycode    = 8'h1B;
    frame_tick = 1'b1;
    @(negedge Clk);
    keycode = 8'h1D;
    #1 check("b2b_cw", pulses, XCW);
    @(negedge Clk);
    frame_tick = 1'b0;
    #1 check("b2b_ccw", pulses, ZCC);
    @(negedge Clk);
    #1 check("b2b_idle", pulses, NO);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
